// File: rtl/spi_regfile_param.sv
// ---------------------------------------------------------------------------
// spi_regfile_param
//   SPI mode-0 peripheral in front of a generic register bank. The controller
//   sends frames of 1 + ADDR_W + DATA_W bits, MSB first: R/W (1 = write),
//   address, data. Completed writes commit to the bank. Aborted frames and
//   out-of-range addresses raise sticky error flags.
//
//   Optional feature: define SPI_READBACK_EN to return reg[addr] on cipo
//   during the data phase of read frames. Without it cipo/cipo_oe are tied 0.
//
// Ports
//   clk        system clock
//   rst        synchronous reset, active-high
//   cs         chip select, active-low (asynchronous to clk)
//   sclk       SPI clock (asynchronous to clk)
//   copi       controller-out peripheral-in data
//   cipo       peripheral-out data
//   cipo_oe    output enable for the cipo pad
//   regs_flat  register bank, reg i at [i*DATA_W +: DATA_W]
//   wr_strobe  one-cycle pulse per committed write
//   wr_addr    address of the last committed write
//   err_addr   sticky: access to an address >= NUM_REGS
//   err_frame  sticky: cs released mid-frame
// ---------------------------------------------------------------------------
module spi_regfile_param #(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int NUM_REGS    = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cs,
    input  logic                       sclk,
    input  logic                       copi,
    output logic                       cipo,
    output logic                       cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic                       wr_strobe,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       err_addr,
    output logic                       err_frame
);

    typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, COMMIT, DONE} state_t;

    localparam int MAX_CNT = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    // Bit 0 takes the raw pin, bit SYNC_STAGES-1 is the newest synchronised
    // value and bit SYNC_STAGES is the history flop used for edge detection.
    logic [SYNC_STAGES:0] cs_sync, sclk_sync, copi_sync;

    state_t                state, state_n;
    logic [CNT_W-1:0]      cnt;
    logic [ADDR_W-1:0]     cmd_sr;
    logic [ADDR_W-1:0]     cmd_next;
    logic [DATA_W-1:0]     data_sr;
    logic [DATA_W-1:0]     reg_q [NUM_REGS];

    logic cs_s, cs_h, sclk_s, sclk_h, copi_s;
    logic cs_fall, cs_rise, sclk_rise;
    logic final_rise, abort, addr_ok, rd_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            cs_sync   <= '1;
            sclk_sync <= '0;
            copi_sync <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples the pre-edge value of its neighbour, forming a true chain.
            cs_sync   <= {cs_sync[SYNC_STAGES-1:0], cs};
            sclk_sync <= {sclk_sync[SYNC_STAGES-1:0], sclk};
            copi_sync <= {copi_sync[SYNC_STAGES-1:0], copi};
        end
    end

    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign cs_h      = cs_sync[SYNC_STAGES];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign sclk_h    = sclk_sync[SYNC_STAGES];
    // copi is held for a whole half-period around the rise, so the sample one
    // cycle older than the sclk edge is just as valid as the newest one.
    assign copi_s    = copi_sync[SYNC_STAGES];
    assign cs_fall   = cs_h & ~cs_s;
    assign cs_rise   = ~cs_h & cs_s;
    assign sclk_rise = ~sclk_h & sclk_s;

    assign cmd_next   = ADDR_W'({cmd_sr, copi_s});
    assign final_rise = sclk_rise && (cnt == CNT_W'(DATA_W - 1));
    assign addr_ok    = int'(cmd_sr) < NUM_REGS;

    // A cs rise landing on the same cycle as the last data bit still lets the
    // frame complete; anywhere else in an active frame it is an abort.
    assign abort = !cs_fall && cs_rise &&
                   ((state == CMD) ||
                    (((state == WDATA) || (state == RDATA)) && !final_rise));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        // NOTE: defaulting every combinational output first prevents latches
        // on paths where no branch assigns it.
        state_n = state;
        if (cs_fall) begin
            state_n = CMD;
        end else if (abort) begin
            state_n = IDLE;
        end else begin
            case (state)
                CMD:
                    if (sclk_rise && (cnt == CNT_W'(ADDR_W)))
                        state_n = cmd_sr[ADDR_W-1] ? WDATA : RDATA;
                WDATA:   if (final_rise) state_n = COMMIT;
                RDATA:   if (final_rise) state_n = DONE;
                COMMIT:  state_n = DONE;
                DONE:    if (cs_s) state_n = IDLE;
                default: ;
            endcase
        end
    end

    assign wr_strobe = (state == COMMIT) && addr_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            cmd_sr    <= '0;
            data_sr   <= '0;
            wr_addr   <= '0;
            err_addr  <= 1'b0;
            err_frame <= 1'b0;
            // NOTE: the bank is a small flop array feeding live control
            // outputs, so it is reset explicitly rather than left unknown.
            for (int i = 0; i < NUM_REGS; i++) reg_q[i] <= '0;
        end else begin
            if (abort)  err_frame <= 1'b1;
            if (rd_err) err_addr  <= 1'b1;

            if (cs_fall) begin
                cnt     <= '0;
                cmd_sr  <= '0;
                data_sr <= '0;
            end else if (sclk_rise) begin
                case (state)
                    CMD: begin
                        cmd_sr <= cmd_next;
                        cnt    <= (cnt == CNT_W'(ADDR_W)) ? '0 : cnt + 1'b1;
                    end
                    WDATA: begin
                        data_sr <= DATA_W'({data_sr, copi_s});
                        cnt     <= cnt + 1'b1;
                    end
                    RDATA:   cnt <= cnt + 1'b1;
                    default: ;
                endcase
            end

            if (state == COMMIT) begin
                if (addr_ok) begin
                    wr_addr <= cmd_sr;
                    for (int i = 0; i < NUM_REGS; i++)
                        if (cmd_sr == ADDR_W'(i)) reg_q[i] <= data_sr;
                end else begin
                    err_addr <= 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[g*DATA_W +: DATA_W] = reg_q[g];
    end

`ifdef SPI_READBACK_EN
    logic [DATA_W-1:0] rd_sr, rd_word;
    logic              rd_oe, enter_rd, sclk_fall;

    assign sclk_fall = sclk_h & ~sclk_s;
    assign enter_rd  = (state == CMD) && (state_n == RDATA);
    assign rd_err    = enter_rd && (int'(cmd_next) >= NUM_REGS);

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (cmd_next == ADDR_W'(i)) rd_word = reg_q[i];
    end

    // The MSB is presented on entry; shifting starts only with the fall that
    // follows the first data rise so the controller samples it first.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_sr <= '0;
            rd_oe <= 1'b0;
        end else if (cs_fall || (state_n == IDLE)) begin
            rd_sr <= '0;
            rd_oe <= 1'b0;
        end else if (enter_rd) begin
            rd_sr <= rd_word;
            rd_oe <= 1'b1;
        end else if ((state == RDATA) && sclk_fall && (cnt != '0)) begin
            rd_sr <= rd_sr << 1;
        end
    end

    assign cipo    = rd_sr[DATA_W-1];
    assign cipo_oe = rd_oe;
`else
    assign rd_err  = 1'b0;
    assign cipo    = 1'b0;
    assign cipo_oe = 1'b0;
`endif

endmodule

// File: tb/tb_spi_regfile_param.sv
// ---------------------------------------------------------------------------
// tb_spi_regfile_param
//   Drives two instances (default parameters and ADDR_W=4/DATA_W=16/
//   NUM_REGS=16) with directed and random SPI frames and compares them with
//   a register-array model of the frame rules.
// ---------------------------------------------------------------------------
module tb_spi_regfile_param;

    localparam int A0 = 7, D0 = 8,  N0 = 5;
    localparam int A1 = 4, D1 = 16, N1 = 16;
    localparam int HALF = 8;  // clk cycles per sclk half-period

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic cs0 = 1'b1, sclk0 = 1'b0, copi0 = 1'b0;
    logic cipo0, oe0, strb0, ea0, ef0;
    logic [N0*D0-1:0] regs0;
    logic [A0-1:0]    wa0;

    logic cs1 = 1'b1, sclk1 = 1'b0, copi1 = 1'b0;
    logic cipo1, oe1, strb1, ea1, ef1;
    logic [N1*D1-1:0] regs1;
    logic [A1-1:0]    wa1;

    spi_regfile_param dut0 (
        .clk(clk), .rst(rst), .cs(cs0), .sclk(sclk0), .copi(copi0),
        .cipo(cipo0), .cipo_oe(oe0), .regs_flat(regs0), .wr_strobe(strb0),
        .wr_addr(wa0), .err_addr(ea0), .err_frame(ef0)
    );

    spi_regfile_param #(.ADDR_W(A1), .DATA_W(D1), .NUM_REGS(N1), .SYNC_STAGES(2)) dut1 (
        .clk(clk), .rst(rst), .cs(cs1), .sclk(sclk1), .copi(copi1),
        .cipo(cipo1), .cipo_oe(oe1), .regs_flat(regs1), .wr_strobe(strb1),
        .wr_addr(wa1), .err_addr(ea1), .err_frame(ef1)
    );

    always #5 clk = ~clk;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference model
    int  m0 [N0];
    int  m1 [N1];
    bit  me_a0, me_f0, me_a1, me_f1;
    int  strobes0 = 0, strobes1 = 0;
    int  exp_addr0 = 0, exp_data0 = 0, exp_addr1 = 0, exp_data1 = 0;
    logic [31:0] rd_word;
    bit  oe_all, oe_any;

    task automatic model_reset();
        foreach (m0[i]) m0[i] = 0;
        foreach (m1[i]) m1[i] = 0;
        me_a0 = 0; me_f0 = 0; me_a1 = 0; me_f1 = 0;
    endtask

    // A committed write must show the old value in the strobe cycle and the
    // new value (and wr_addr) in the cycle right after it.
    bit prev0 = 0, prev1 = 0;
    always @(negedge clk) begin
        if (prev0) begin
            check("commit_reg0", regs0[exp_addr0*D0 +: D0], exp_data0);
            check("wr_addr0", wa0, exp_addr0);
        end
        if (strb0 === 1'b1) begin
            strobes0++;
            check("strobe_cycle_reg0", regs0[exp_addr0*D0 +: D0], m0[exp_addr0 % N0]);
        end
        prev0 = (strb0 === 1'b1);
        if (prev1) begin
            check("commit_reg1", regs1[exp_addr1*D1 +: D1], exp_data1);
            check("wr_addr1", wa1, exp_addr1);
        end
        if (strb1 === 1'b1) begin
            strobes1++;
            check("strobe_cycle_reg1", regs1[exp_addr1*D1 +: D1], m1[exp_addr1 % N1]);
        end
        prev1 = (strb1 === 1'b1);
    end

    task automatic set_pins(input int d, input logic c, input logic s, input logic o);
        if (d == 0) begin cs0 = c; sclk0 = s; copi0 = o; end
        else        begin cs1 = c; sclk1 = s; copi1 = o; end
    endtask

    function automatic logic get_cipo(input int d);
        return (d == 0) ? cipo0 : cipo1;
    endfunction

    function automatic logic get_oe(input int d);
        return (d == 0) ? oe0 : oe1;
    endfunction

    // Sends up to stop_after bits of an nbits frame; rst_at >= 0 releases cs
    // and pulses rst before that bit instead of finishing the frame.
    task automatic run_frame(input int d, input int nbits, input logic [31:0] bits,
                             input int stop_after, input int rd_start, input int rst_at);
        logic o;
        o = 1'b0;
        rd_word = '0; oe_all = 1; oe_any = 0;
        set_pins(d, 1'b0, 1'b0, 1'b0);
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nbits && i < stop_after; i++) begin
            if (i == rst_at) begin
                set_pins(d, 1'b1, 1'b0, 1'b0);
                rst = 1'b1;
                repeat (4) @(negedge clk);
                rst = 1'b0;
                repeat (2*HALF) @(negedge clk);
                return;
            end
            o = bits[nbits-1-i];
            set_pins(d, 1'b0, 1'b0, o);
            repeat (HALF) @(negedge clk);
            if (i >= rd_start) begin
                rd_word = {rd_word[30:0], get_cipo(d)};
                oe_all  = oe_all & get_oe(d);
                oe_any  = oe_any | get_oe(d);
            end
            set_pins(d, 1'b0, 1'b1, o);
            repeat (HALF) @(negedge clk);
        end
        set_pins(d, 1'b0, 1'b0, o);
        repeat (HALF) @(negedge clk);
        set_pins(d, 1'b1, 1'b0, o);
        repeat (2*HALF) @(negedge clk);
    endtask

    task automatic compare_all(input int d);
        if (d == 0) begin
            for (int i = 0; i < N0; i++)
                check($sformatf("reg0[%0d]", i), regs0[i*D0 +: D0], m0[i]);
            check("err_addr0", ea0, me_a0);
            check("err_frame0", ef0, me_f0);
            check("cipo_oe0_idle", oe0, 0);
        end else begin
            for (int i = 0; i < N1; i++)
                check($sformatf("reg1[%0d]", i), regs1[i*D1 +: D1], m1[i]);
            check("err_addr1", ea1, me_a1);
            check("err_frame1", ef1, me_f1);
            check("cipo_oe1_idle", oe1, 0);
        end
    endtask

    task automatic do_frame(input int d, input bit rw, input int addr, input int data,
                            input int stop_after);
        int aw, dw, nregs, nbits, s_before, exp_strobes, rd_exp;
        logic [31:0] bits;
        aw    = (d == 0) ? A0 : A1;
        dw    = (d == 0) ? D0 : D1;
        nregs = (d == 0) ? N0 : N1;
        nbits = 1 + aw + dw;
        bits  = (32'(rw) << (aw + dw)) | (32'(addr) << dw) | 32'(data);
        if (d == 0) begin exp_addr0 = addr; exp_data0 = data; s_before = strobes0; end
        else        begin exp_addr1 = addr; exp_data1 = data; s_before = strobes1; end

        run_frame(d, nbits, bits, stop_after, 1 + aw, -1);

        exp_strobes = 0;
        if (stop_after < nbits) begin
            if (d == 0) me_f0 = 1; else me_f1 = 1;
        end else if (rw) begin
            if (addr < nregs) begin
                exp_strobes = 1;
                if (d == 0) m0[addr] = data; else m1[addr] = data;
            end else begin
                if (d == 0) me_a0 = 1; else me_a1 = 1;
            end
        end else begin
`ifdef SPI_READBACK_EN
            rd_exp = 0;
            if (addr < nregs) rd_exp = (d == 0) ? m0[addr] : m1[addr];
            else if (d == 0) me_a0 = 1;
            else me_a1 = 1;
            check($sformatf("read_data%0d", d), rd_word, rd_exp);
            check($sformatf("read_oe%0d", d), oe_all, 1);
`else
            rd_exp = 0;
            check($sformatf("read_oe_off%0d", d), {oe_any, rd_word}, rd_exp);
`endif
        end
        check($sformatf("strobe_count%0d", d),
              (d == 0) ? strobes0 - s_before : strobes1 - s_before, exp_strobes);
        compare_all(d);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rw_r, addr_r, data_r, stop_r;
        model_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_strobe0", strb0, 0);
        check("reset_strobe1", strb1, 0);
        check("reset_wr_addr0", wa0, 0);
        compare_all(0);
        compare_all(1);

        do_frame(0, 1, 3, 'hA5, 99);           // plain write
        do_frame(0, 1, 9, 'hFF, 99);           // out-of-range write
        do_frame(0, 1, 1, 'h77, 10);           // aborted after 10 bits
        do_frame(0, 1, 1, 'h3C, 99);           // recovery write
        do_frame(0, 1, 4, 'h81, 99);
        do_frame(0, 0, 4, 0, 99);              // read-back of 0x81
        do_frame(0, 0, 2, 0, 99);
        do_frame(1, 1, 15, 'hBEEF, 99);        // wide instance, top register
        check("beef_top", regs1[255:240], 16'hBEEF);

        // Reset in the middle of a write: frame discarded, bank cleared.
        exp_addr1 = 15; exp_data1 = 'h1234;
        begin
            int s_before;
            s_before = strobes1;
            run_frame(1, 21, {11'd0, 1'b1, 4'd15, 16'h1234}, 99, 5, 12);
            model_reset();
            check("rst_mid_frame_strobe", strobes1 - s_before, 0);
            compare_all(0);
            compare_all(1);
        end

        for (int n = 0; n < 40; n++) begin
            rw_r   = ($urandom_range(0, 3) != 0) ? 1 : 0;
            addr_r = $urandom_range(0, 9);
            data_r = $urandom_range(0, 255);
            stop_r = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 15) : 99;
            do_frame(0, rw_r[0], addr_r, data_r, stop_r);
        end
        for (int n = 0; n < 12; n++) begin
            rw_r   = ($urandom_range(0, 3) != 0) ? 1 : 0;
            addr_r = $urandom_range(0, 15);
            data_r = $urandom_range(0, 65535);
            stop_r = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 20) : 99;
            do_frame(1, rw_r[0], addr_r, data_r, stop_r);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
